// File: rtl/nios2_ram_arbiter_if.sv
// Avalon-MM request/response bundle between one bus master and the RAM arbiter.
interface nios2_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BE_W   = 2
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios2_ram_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM
// masters; tracks the RAM's one-cycle read latency to steer returned data.
module nios2_ram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BE_W   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    nios2_ram_arbiter_if.slave m0,
    nios2_ram_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]  ram_address,
    output logic [BE_W-1:0]    ram_byteenable,
    output logic               ram_chipselect,
    output logic               ram_write,
    output logic [DATA_W-1:0]  ram_writedata,
    output logic               ram_clken,
    input  logic [DATA_W-1:0]  ram_readdata
);

    logic last_grant_q, last_grant_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_port_q, rd_port_d;
    logic req0_c, req1_c;
    logic gnt0_c, gnt1_c;

    // Grant: lone requester wins; on contention the port not granted last wins
    always_comb begin
        req0_c = m0.read | m0.write;
        req1_c = m1.read | m1.write;
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (reset_n) begin
            if (req0_c && req1_c) begin
                gnt0_c = last_grant_q;
                gnt1_c = ~last_grant_q;
            end else begin
                gnt0_c = req0_c;
                gnt1_c = req1_c;
            end
        end
    end

    // Next state: last_grant holds through idle cycles; a write wins over a read
    always_comb begin
        last_grant_d = last_grant_q;
        rd_pend_d    = 1'b0;
        rd_port_d    = rd_port_q;
        if (gnt0_c || gnt1_c) begin
            last_grant_d = gnt1_c;
            rd_port_d    = gnt1_c;
            rd_pend_d    = (gnt0_c & m0.read & ~m0.write) |
                           (gnt1_c & m1.read & ~m1.write);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_port_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_port_q    <= rd_port_d;
        end
    end

    // RAM drive: port 0 values sit on the data buses whenever port 1 is not granted
    always_comb begin
        ram_address    = m0.address;
        ram_byteenable = m0.byteenable;
        ram_writedata  = m0.writedata;
        ram_chipselect = gnt0_c | gnt1_c;
        ram_write      = gnt0_c & m0.write;
        ram_clken      = reset_n;
        if (gnt1_c) begin
            ram_address    = m1.address;
            ram_byteenable = m1.byteenable;
            ram_writedata  = m1.writedata;
            ram_write      = m1.write;
        end
    end

    assign m0.waitrequest   = ~reset_n | (req0_c & ~gnt0_c);
    assign m1.waitrequest   = ~reset_n | (req1_c & ~gnt1_c);
    assign m0.readdata      = ram_readdata;
    assign m1.readdata      = ram_readdata;
    assign m0.readdatavalid = rd_pend_q & ~rd_port_q;
    assign m1.readdatavalid = rd_pend_q & rd_port_q;

endmodule

// File: tb/tb_nios2_ram_arbiter.sv
// Scoreboard bench for nios2_ram_arbiter: directed scenarios plus random traffic
// against a reference memory and round-robin rule model.
module tb_nios2_ram_arbiter;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios2_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0 ();
    nios2_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1 ();

    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic              ram_clken;
    logic [DATA_W-1:0] ram_readdata;

    nios2_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0),
        .m1             (m1),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
    );

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] be);
        merge = o;
        if (be[0]) merge[7:0]  = n[7:0];
        if (be[1]) merge[15:8] = n[15:8];
    endfunction

    function automatic logic [15:0] init_val(input int i);
        if (i == 1)     return 16'h1111;
        if (i == 2)     return 16'h2222;
        if (i == 'h20)  return 16'h1234;
        return 16'(i * 37 + 5);
    endfunction

    // RAM model: synchronous read, byte-lane writes, contents set on first edge
    logic [15:0] ram_mem [0:255];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (ram_clken && ram_chipselect) begin
            if (ram_write)
                ram_mem[ram_address[7:0]] <= merge(ram_mem[ram_address[7:0]], ram_writedata, ram_byteenable);
            else
                ram_readdata <= ram_mem[ram_address[7:0]];
        end
    end

    // Reference model state
    logic [15:0] ref_mem [0:255];
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];
    int  last_gnt = 1;
    bit  pend0 = 1'b0, pend1 = 1'b0;
    bit  acc0 = 1'b0, acc1 = 1'b0;
    int  gcnt0 = 0, gcnt1 = 0;
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop expected read data whenever a port presents readdatavalid
    initial forever begin
        @(negedge clk);
        if (m0.readdatavalid === 1'b1) begin
            if (exp_q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL rdata0_unexpected: got %0h expected none", m0.readdata);
            end else chk("rdata0", 32'(m0.readdata), 32'(exp_q0.pop_front()));
        end
        if (m1.readdatavalid === 1'b1) begin
            if (exp_q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL rdata1_unexpected: got %0h expected none", m1.readdata);
            end else chk("rdata1", 32'(m1.readdata), 32'(exp_q1.pop_front()));
        end
    end

    // One bus cycle: check handshakes at the falling edge, update model, advance
    task automatic step();
        logic r0, r1;
        int   g;
        @(negedge clk);
        r0 = m0.read | m0.write;
        r1 = m1.read | m1.write;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!reset_n) begin
            chk("wait0_rst", 32'(m0.waitrequest), 1);
            chk("wait1_rst", 32'(m1.waitrequest), 1);
            chk("cs_rst", 32'(ram_chipselect), 0);
            chk("clken_rst", 32'(ram_clken), 0);
            chk("rdv0_rst", 32'(m0.readdatavalid), 0);
            chk("rdv1_rst", 32'(m1.readdatavalid), 0);
            last_gnt = 1;
            pend0 = 1'b0;
            pend1 = 1'b0;
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (r0 && r1)  g = 1 - last_gnt;
            else if (r0)   g = 0;
            else if (r1)   g = 1;
            else           g = -1;
            chk("wait0", 32'(m0.waitrequest), 32'(r0 && g != 0));
            chk("wait1", 32'(m1.waitrequest), 32'(r1 && g != 1));
            chk("cs", 32'(ram_chipselect), 32'(g >= 0));
            chk("clken", 32'(ram_clken), 1);
            chk("rdv0", 32'(m0.readdatavalid), 32'(pend0));
            chk("rdv1", 32'(m1.readdatavalid), 32'(pend1));
            pend0 = 1'b0;
            pend1 = 1'b0;
            if (g == 0) begin
                acc0 = 1'b1; gcnt0++; last_gnt = 0;
                chk("addr0", 32'(ram_address), 32'(m0.address));
                chk("we0", 32'(ram_write), 32'(m0.write));
                if (m0.write) begin
                    chk("wdata0", 32'(ram_writedata), 32'(m0.writedata));
                    ref_mem[m0.address[7:0]] = merge(ref_mem[m0.address[7:0]], m0.writedata, m0.byteenable);
                end else begin
                    exp_q0.push_back(ref_mem[m0.address[7:0]]);
                    pend0 = 1'b1;
                end
            end else if (g == 1) begin
                acc1 = 1'b1; gcnt1++; last_gnt = 1;
                chk("addr1", 32'(ram_address), 32'(m1.address));
                chk("we1", 32'(ram_write), 32'(m1.write));
                if (m1.write) begin
                    chk("wdata1", 32'(ram_writedata), 32'(m1.writedata));
                    ref_mem[m1.address[7:0]] = merge(ref_mem[m1.address[7:0]], m1.writedata, m1.byteenable);
                end else begin
                    exp_q1.push_back(ref_mem[m1.address[7:0]]);
                    pend1 = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0.read = 1'b0; m0.write = 1'b0;
        m1.read = 1'b0; m1.write = 1'b0;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic rnd(output logic rd, output logic wr, output logic [15:0] a,
                       output logic [1:0] be, output logic [15:0] d);
        int k;
        k  = int'($urandom_range(0, 4));
        rd = (k == 1) || (k == 2) || (k == 4);
        wr = (k == 3) || (k == 4);
        a  = 16'($urandom_range(0, 63));
        be = 2'($urandom_range(0, 3));
        d  = 16'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        m0.address = '0; m0.byteenable = '0; m0.writedata = '0;
        m1.address = '0; m1.byteenable = '0; m1.writedata = '0;
        idle_all();

        // Reset held three cycles, then idle
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Port 0 write then read back
        m0.write = 1'b1; m0.address = 16'h0010; m0.writedata = 16'hBEEF; m0.byteenable = 2'b11;
        step();
        m0.write = 1'b0; m0.read = 1'b1;
        step();
        idle_all();
        step();

        // Contention straight after reset: port 0 first
        reset_pulse();
        m0.read = 1'b1; m0.address = 16'h0001;
        m1.read = 1'b1; m1.address = 16'h0002;
        step();
        chk("cont_acc0", 32'(acc0), 1);
        m0.read = 1'b0;
        step();
        chk("cont_acc1", 32'(acc1), 1);
        m1.read = 1'b0;
        repeat (2) step();

        // Sustained write contention for eight cycles
        gcnt0 = 0; gcnt1 = 0;
        m0.write = 1'b1; m0.byteenable = 2'b11; m0.address = 16'h0030; m0.writedata = 16'(($urandom));
        m1.write = 1'b1; m1.byteenable = 2'b11; m1.address = 16'h0031; m1.writedata = 16'(($urandom));
        repeat (8) begin
            step();
            if (acc0) begin m0.address = 16'($urandom_range(48, 55)); m0.writedata = 16'($urandom); end
            if (acc1) begin m1.address = 16'($urandom_range(56, 63)); m1.writedata = 16'($urandom); end
        end
        chk("sustain_gcnt0", 32'(gcnt0), 4);
        chk("sustain_gcnt1", 32'(gcnt1), 4);
        idle_all();
        step();

        // Byte-lane write over 0x1234 then read back
        m1.write = 1'b1; m1.address = 16'h0020; m1.writedata = 16'h00AA; m1.byteenable = 2'b01;
        step();
        m1.write = 1'b0; m1.read = 1'b1;
        step();
        chk("bytelane_expect", 32'(exp_q1.size() > 0 ? exp_q1[0] : 16'h0), 32'h12AA);
        idle_all();
        step();

        // Reset asserted while a port 0 read is in flight
        m0.read = 1'b1; m0.address = 16'h0001;
        @(negedge clk);
        chk("midrd_accept", 32'(m0.waitrequest), 0);
        #2;
        reset_n = 1'b0;
        m0.read = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        reset_n = 1'b1;
        chk("midrd_pend", 32'(dut.rd_pend_q), 0);
        chk("midrd_rdv0", 32'(m0.readdatavalid), 0);
        repeat (2) step();

        // Random traffic with Avalon hold-while-waiting behaviour
        for (int n = 0; n < 400; n++) begin
            if (!(m0.read | m0.write) || acc0)
                rnd(m0.read, m0.write, m0.address, m0.byteenable, m0.writedata);
            if (!(m1.read | m1.write) || acc1)
                rnd(m1.read, m1.write, m1.address, m1.byteenable, m1.writedata);
            step();
        end
        idle_all();
        repeat (3) step();
        chk("q0_drained", 32'(exp_q0.size()), 0);
        chk("q1_drained", 32'(exp_q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios2_ram_arbiter.md
Name: nios2_ram_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single-port 16-bit on-chip RAM between the Nios II data master (port 0) and a DMA/peripheral master (port 1).
- Presents two Avalon-MM slave interfaces with waitrequest and readdatavalid.
- Drives the RAM's address, byteenable, chipselect, write, writedata and clken.
- Tracks the RAM's one-cycle read latency and routes returned read data to the requester that issued the read.

Parameters:
ADDR_W, 16, word address width (RAM depth 51200 words fits).
DATA_W, 16, data width.
BE_W, 2, byteenable width (DATA_W/8).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  port 0 word address
m0_byteenable  in  BE_W  port 0 byte lanes
m0_read  in  1  port 0 read request
m0_write  in  1  port 0 write request
m0_writedata  in  DATA_W  port 0 write data
m0_waitrequest  out  1  port 0 stall
m0_readdata  out  DATA_W  port 0 read data
m0_readdatavalid  out  1  port 0 read data strobe
m1_*  same set as m0_*  port 1
ram_address  out  ADDR_W  to RAM address
ram_byteenable  out  BE_W  to RAM byteenable
ram_chipselect  out  1  to RAM chipselect
ram_write  out  1  to RAM write
ram_writedata  out  DATA_W  to RAM writedata
ram_clken  out  1  to RAM clken
ram_readdata  in  DATA_W  from RAM readdata (valid cycle after read issue)

Behaviour:
- Request: reqN = mN_read | mN_write. If both mN_read and mN_write are high, the cycle is a write. No readdatavalid is generated for that cycle.
- Grant is combinational each cycle:
  - Only one port requesting: that port is granted.
  - Both requesting: the port not granted most recently is granted.
  - Neither requesting: no grant, and the last-grant register is unchanged.
- Last-grant register: 1 bit, updated on every granted cycle. Reset value 1, so port 0 wins the first contention.
- Waitrequest: mN_waitrequest = reqN & ~grantN. It is 1 for both ports while reset_n is low. A granted transaction is accepted in the same cycle, so throughput is one access per cycle with no bubbles between grants.
- RAM drive while granted:
  - ram_address/byteenable/writedata come from the granted port.
  - ram_chipselect = 1.
  - ram_write = the granted port's write.
- RAM drive with no grant: ram_chipselect = 0, ram_write = 0, data buses hold port 0 values (don't care).
- ram_clken = 1 when reset_n is high, 0 while in reset.
- Read return pipeline:
  - Registers rd_pend (1b) and rd_port (1b) capture the granted read at the clock edge.
  - On the next cycle, mX_readdatavalid = rd_pend & (rd_port == X), and mX_readdata = ram_readdata.
  - Read latency is 1 cycle after acceptance. Back-to-back reads from alternating ports return in issue order, one per cycle.
- readdata of the non-returning port equals ram_readdata and is not qualified (ignore it).
- Reset values: rd_pend = 0, rd_port = 0, last_grant = 1. All readdatavalid = 0 and all waitrequest = 1 during reset.
- Reset deasserted mid-read: a read accepted in the cycle before reset asserts is dropped; no readdatavalid is produced after reset.
- Write-then-read to the same address on consecutive cycles returns the new data, since the RAM commits the write on the first edge.
- A same-cycle read/write collision between ports cannot occur, because only one port is granted per cycle.
- No timeouts and no locking. Fairness guarantee: a continuously requesting port waits at most 1 cycle.

Test Plan:
- Reset then idle: reset_n low for 3 cycles -> both waitrequest = 1, ram_chipselect = 0, readdatavalid = 0. After release with no requests -> waitrequest = 0, chipselect = 0.
- Single-port write then read: m0 writes 0xBEEF to address 0x0010 with byteenable 2'b11, then m0 reads 0x0010 -> write accepted cycle 1, read accepted cycle 2, m0_readdatavalid = 1 with readdata = 0xBEEF in cycle 3. m1 sees no readdatavalid.
- Contention after reset: m0 and m1 both read (addresses 0x0001 and 0x0002, preloaded 0x1111 and 0x2222) in the same cycle -> m0 is granted first and m1 waits 1 cycle. Returns are m0 = 0x1111, then m1 = 0x2222 on consecutive cycles.
- Sustained contention: both ports hold write requests for 8 cycles -> grants alternate 0,1,0,1..., each port completes 4 writes, and no waitrequest lasts longer than 1 cycle.
- Byte-lane write: m1 writes 0x00AA with byteenable 2'b01 over a word holding 0x1234, then reads it -> readdata = 0x12AA.
- Reset mid-read: m0 read accepted, then reset_n is pulled low before the next edge completes and released 2 cycles later -> m0_readdatavalid never asserts and rd_pend = 0 after reset.
